// File: rtl/snn_tick_scheduler_if.sv
// Start/done handshake and spike bus between the tick scheduler and the u/v/current engine.
interface snn_tick_scheduler_if #(
  parameter int NN = 4
);
  logic          uv_start;
  logic          uv_done;
  logic          curr_start;
  logic          curr_done;
  logic          engine_reset;
  logic [NN-1:0] spike_in;

  modport master (
    output uv_start, curr_start, engine_reset,
    input  uv_done, curr_done, spike_in
  );

  modport slave (
    input  uv_start, curr_start, engine_reset,
    output uv_done, curr_done, spike_in
  );
endinterface

// File: rtl/snn_tick_scheduler.sv
// Tick sequencer for the spiking core: u/v phase, current phase, spike capture, overrun flagging.
// Optional overrun_count output enabled by defining SNN_SCHED_OVERRUN_CNT_EN.
module snn_tick_scheduler #(
  parameter int NN       = 4,
  parameter int PERIOD_W = 16,
  parameter int TICK_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  snn_tick_scheduler_if.master eng,
  output logic [NN-1:0]       spikearray,
  output logic                spike_valid,
  output logic [TICK_W-1:0]   tick_count,
  output logic                busy,
  output logic                overrun
`ifdef SNN_SCHED_OVERRUN_CNT_EN
  ,
  output logic [15:0]         overrun_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    UV,
    CURR,
    WAIT,
    WRAP
  } state_t;

  state_t              state, state_d;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] period_clamped;
  logic                tick;
  logic                in_phase;

  always_comb begin
    period_clamped = (period < PERIOD_W'(4)) ? PERIOD_W'(4) : period;
    tick           = (state != IDLE) && (cnt == period_q - PERIOD_W'(1));
    in_phase       = (state == UV) || (state == CURR);
  end

  // Overrun ticks leave the state alone; the phase just finishes late and WAIT absorbs it.
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (enable)        state_d = UV;
      UV:      if (eng.uv_done)   state_d = CURR;
      CURR:    if (eng.curr_done) state_d = WAIT;
      WAIT:    if (tick)          state_d = WRAP;
      WRAP:                       state_d = UV;
      default:                    state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  // Outputs are registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      period_q         <= PERIOD_W'(4);
      eng.uv_start     <= 1'b0;
      eng.curr_start   <= 1'b0;
      eng.engine_reset <= 1'b1;
      spikearray       <= '0;
      spike_valid      <= 1'b0;
      tick_count       <= '0;
      busy             <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state <= state_d;

      if (state == IDLE || state_d == IDLE) begin
        cnt      <= '0;
        period_q <= period_clamped;
      end else if (tick) begin
        cnt      <= '0;
        period_q <= period_clamped;
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end

      if (state_d == IDLE)  tick_count <= '0;
      else if (tick)        tick_count <= tick_count + TICK_W'(1);

      eng.uv_start     <= (state_d == UV)   && (state != UV);
      eng.curr_start   <= (state_d == CURR) && (state != CURR);
      eng.engine_reset <= (state_d == IDLE) || (state_d == WRAP);
      busy             <= (state_d == UV)   || (state_d == CURR);
      overrun          <= tick && in_phase;

      spike_valid <= (state == CURR) && (state_d == WAIT);
      if ((state == CURR) && (state_d == WAIT)) spikearray <= eng.spike_in;
    end
  end

`ifdef SNN_SCHED_OVERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                                     overrun_count <= '0;
    else if (tick && in_phase && overrun_count != '1) overrun_count <= overrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_snn_tick_scheduler.sv
// Directed bench for snn_tick_scheduler with a latency-programmable engine model.
module tb_snn_tick_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [3:0]  spikearray;
  logic        spike_valid;
  logic [15:0] tick_count;
  logic        busy;
  logic        overrun;
`ifdef SNN_SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  snn_tick_scheduler_if #(.NN(4)) eng ();

  snn_tick_scheduler #(
    .NN(4),
    .PERIOD_W(16),
    .TICK_W(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .eng(eng),
    .spikearray(spikearray),
    .spike_valid(spike_valid),
    .tick_count(tick_count),
    .busy(busy),
    .overrun(overrun)
`ifdef SNN_SCHED_OVERRUN_CNT_EN
    ,
    .overrun_count(overrun_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int uv_lat = 3, curr_lat = 2;
  int uv_rem = 0, curr_rem = 0;
  bit uv_pend = 0, curr_pend = 0;
  bit man_uv = 0;
  logic [3:0] spike_pat = 4'b1010;
  int ov_n = 0, sv_n = 0;
  int ov0, sv0;

  // Engine model: done pulses lat cycles after the start pulse is seen.
  always @(posedge clk) begin
    #1;
    if (eng.uv_start) begin uv_pend = 1; uv_rem = uv_lat; end
    else if (uv_pend) begin if (uv_rem == 0) uv_pend = 0; else uv_rem--; end
    if (eng.curr_start) begin curr_pend = 1; curr_rem = curr_lat; end
    else if (curr_pend) begin if (curr_rem == 0) curr_pend = 0; else curr_rem--; end
    eng.uv_done   = (uv_pend && uv_rem == 0) || man_uv;
    eng.curr_done = curr_pend && curr_rem == 0;
    eng.spike_in  = spike_pat;
    if (overrun)     ov_n++;
    if (spike_valid) sv_n++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_uv_start"}, eng.uv_start, 0);
    check_eq({tag, "_curr_start"}, eng.curr_start, 0);
    check_eq({tag, "_engine_reset"}, eng.engine_reset, 1);
    check_eq({tag, "_spikearray"}, spikearray, 0);
    check_eq({tag, "_spike_valid"}, spike_valid, 0);
    check_eq({tag, "_tick_count"}, tick_count, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_overrun"}, overrun, 0);
  endtask

  initial begin
    eng.uv_done   = 1'b0;
    eng.curr_done = 1'b0;
    eng.spike_in  = '0;
    reset  = 1'b1;
    enable = 1'b0;
    period = 16'd20;
    step(3);
    check_reset_values("rst");
    reset = 1'b0;
    step(1);

    // Normal run, period 20, uv latency 3, curr latency 2
    enable = 1'b1;
    step(1);
    check_eq("t1_c0_uv_start", eng.uv_start, 1);
    check_eq("t1_c0_busy", busy, 1);
    check_eq("t1_c0_engine_reset", eng.engine_reset, 0);
    step(4);
    check_eq("t1_c4_curr_start", eng.curr_start, 1);
    check_eq("t1_c4_uv_start", eng.uv_start, 0);
    step(2);
    check_eq("t1_c6_spikearray", spikearray, 0);
    step(1);
    check_eq("t1_c7_spike_valid", spike_valid, 1);
    check_eq("t1_c7_spikearray", spikearray, 4'b1010);
    check_eq("t1_c7_busy", busy, 0);
    step(12);
    check_eq("t1_c19_tick_count", tick_count, 0);
    step(1);
    check_eq("t1_c20_engine_reset", eng.engine_reset, 1);
    check_eq("t1_c20_tick_count", tick_count, 1);
    step(1);
    check_eq("t1_c21_uv_start", eng.uv_start, 1);
    step(20);
    check_eq("t1_c41_uv_start", eng.uv_start, 1);
    check_eq("t1_c41_tick_count", tick_count, 2);
    check_eq("t1_no_overrun", ov_n, 0);
    step(4);
    check_eq("t1_c45_curr_start", eng.curr_start, 1);

    // Enable dropped in CURR
    enable = 1'b0;
    step(1);
    check_eq("t1_drop_engine_reset", eng.engine_reset, 1);
    check_eq("t1_drop_tick_count", tick_count, 0);
    check_eq("t1_drop_busy", busy, 0);
    check_eq("t1_drop_spikearray", spikearray, 4'b1010);
    sv0 = sv_n;
    enable = 1'b1;
    step(1);
    check_eq("t1_reen_uv_start", eng.uv_start, 1);
    step(3);
    check_eq("t1_reen_r3_busy", busy, 1);
    check_eq("t1_reen_r3_curr_start", eng.curr_start, 0);
    step(1);
    check_eq("t1_reen_r4_curr_start", eng.curr_start, 1);
    check_eq("t1_reen_no_spike_valid", sv_n, sv0);
    enable = 1'b0;
    step(3);

    // Period 2 clamps to 4
    period   = 16'd2;
    uv_lat   = 0;
    curr_lat = 0;
    ov0      = ov_n;
    enable   = 1'b1;
    step(1);
    check_eq("t2_c0_uv_start", eng.uv_start, 1);
    step(4);
    check_eq("t2_c4_engine_reset", eng.engine_reset, 1);
    check_eq("t2_c4_tick_count", tick_count, 1);
    step(1);
    check_eq("t2_c5_uv_start", eng.uv_start, 1);
    step(4);
    check_eq("t2_c9_uv_start", eng.uv_start, 1);
    check_eq("t2_c9_tick_count", tick_count, 2);
    check_eq("t2_no_overrun", ov_n, ov0);
    enable = 1'b0;
    step(3);

    // Overrun: curr_done 30 cycles after curr_start with period 20
    period    = 16'd20;
    uv_lat    = 3;
    curr_lat  = 30;
    spike_pat = 4'b0101;
    ov0       = ov_n;
    enable    = 1'b1;
    step(1);
    check_eq("t3_c0_uv_start", eng.uv_start, 1);
    step(19);
    check_eq("t3_c19_overrun", overrun, 0);
    step(1);
    check_eq("t3_c20_overrun", overrun, 1);
    check_eq("t3_c20_busy", busy, 1);
    check_eq("t3_c20_tick_count", tick_count, 1);
    step(1);
    check_eq("t3_c21_overrun", overrun, 0);
    step(13);
    check_eq("t3_c34_spike_valid", spike_valid, 0);
    check_eq("t3_c34_busy", busy, 1);
    step(1);
    check_eq("t3_c35_spike_valid", spike_valid, 1);
    check_eq("t3_c35_spikearray", spikearray, 4'b0101);
    check_eq("t3_c35_busy", busy, 0);
    step(4);
    check_eq("t3_c39_uv_start", eng.uv_start, 0);
    check_eq("t3_c39_engine_reset", eng.engine_reset, 0);
    step(1);
    check_eq("t3_c40_engine_reset", eng.engine_reset, 1);
    check_eq("t3_c40_tick_count", tick_count, 2);
    step(1);
    check_eq("t3_c41_uv_start", eng.uv_start, 1);
    check_eq("t3_one_overrun", ov_n - ov0, 1);
`ifdef SNN_SCHED_OVERRUN_CNT_EN
    check_eq("t3_overrun_count", overrun_count, 1);
`endif

    // Reset asserted while in WAIT
    curr_lat = 2;
    step(9);
    check_eq("t4_wait_busy", busy, 0);
    check_eq("t4_wait_tick_count", tick_count, 2);
    reset = 1'b1;
    step(1);
    check_reset_values("t4_rst");
`ifdef SNN_SCHED_OVERRUN_CNT_EN
    check_eq("t4_rst_overrun_count", overrun_count, 0);
`endif
    reset  = 1'b0;
    enable = 1'b0;
    man_uv = 1'b1;
    step(1);
    man_uv = 1'b0;
    step(3);
    check_eq("t4_spurious_uv_start", eng.uv_start, 0);
    check_eq("t4_spurious_curr_start", eng.curr_start, 0);
    check_eq("t4_spurious_busy", busy, 0);
    check_eq("t4_spurious_engine_reset", eng.engine_reset, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
